// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI packet scheduler slice.
// Optional feature macro used by this slice: DSI_SCHED_STARVE_GUARD_EN.
package dsi_pkg;

    localparam int DSI_WORD_W = 32;
    localparam int DSI_STRB_W = 4;

    localparam logic DSI_MODE_HS = 1'b0;
    localparam logic DSI_MODE_LP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_STREAM = 3'd3,
        ST_GAP    = 3'd4
    } sched_state_t;

    // Byte strobes only carry information on the final word of a packet;
    // every earlier word is a full word.
    function automatic logic [DSI_STRB_W-1:0] word_strb(
        input logic                  last,
        input logic [DSI_STRB_W-1:0] strb
    );
        logic [DSI_STRB_W-1:0] res;
        if (last) begin
            res = strb;
        end else begin
            res = 4'hF;
        end
        return res;
    endfunction

endpackage

// File: rtl/dsi_packet_scheduler_if.sv
// Bus bundle between the two packet sources, the scheduler and the lanes
// controller. The scheduler uses the slave view, the environment the master.
interface dsi_packet_scheduler_if;

    logic                          lines_ready;

    logic                          vid_valid;
    logic                          vid_last;
    logic [dsi_pkg::DSI_WORD_W-1:0] vid_data;
    logic [dsi_pkg::DSI_STRB_W-1:0] vid_strb;
    logic                          vid_ready;

    logic                          cmd_valid;
    logic                          cmd_last;
    logic [dsi_pkg::DSI_WORD_W-1:0] cmd_data;
    logic [dsi_pkg::DSI_STRB_W-1:0] cmd_strb;
    logic                          cmd_ready;
    logic                          cmd_lp;

    logic [dsi_pkg::DSI_WORD_W-1:0] tx_write_data;
    logic [4:0]                    tx_write_strb;
    logic                          tx_write_rqst;
    logic                          tx_last_word;
    logic                          tx_data_rqst;

    logic                          busy;
    logic                          grant_cmd;
    logic                          underflow_err;

    modport slave (
        input  lines_ready,
        input  vid_valid, vid_last, vid_data, vid_strb,
        output vid_ready,
        input  cmd_valid, cmd_last, cmd_data, cmd_strb, cmd_lp,
        output cmd_ready,
        output tx_write_data, tx_write_strb, tx_write_rqst, tx_last_word,
        input  tx_data_rqst,
        output busy, grant_cmd, underflow_err
    );

    modport master (
        output lines_ready,
        output vid_valid, vid_last, vid_data, vid_strb,
        input  vid_ready,
        output cmd_valid, cmd_last, cmd_data, cmd_strb, cmd_lp,
        input  cmd_ready,
        input  tx_write_data, tx_write_strb, tx_write_rqst, tx_last_word,
        output tx_data_rqst,
        input  busy, grant_cmd, underflow_err
    );

endinterface

// File: rtl/dsi_sched_arbiter.sv
// Combinational source selection for the DSI packet scheduler.
// Video has priority; with DSI_SCHED_STARVE_GUARD_EN a command that has
// waited through STARVE_LIMIT video grants wins instead.
module dsi_sched_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       vid_valid,
    input  logic       cmd_valid,
    input  logic [7:0] starve_cnt,
    output logic       sel_cmd,
    output logic       sel_any
);

`ifdef DSI_SCHED_STARVE_GUARD_EN
    // Priority select with forced command grant once video has starved it.
    always_comb begin
        sel_any = vid_valid | cmd_valid;
        sel_cmd = cmd_valid & (~vid_valid | (starve_cnt == 8'(STARVE_LIMIT)));
    end
`else
    logic unused_starve_s;
    assign unused_starve_s = ^{starve_cnt, 8'(STARVE_LIMIT)};

    // Strict video-over-command priority.
    always_comb begin
        sel_any = vid_valid | cmd_valid;
        sel_cmd = cmd_valid & ~vid_valid;
    end
`endif

endmodule

// File: rtl/dsi_packet_scheduler.sv
// DSI packet scheduler: grants whole packets from the video engine or the
// host command queue onto the lanes controller word interface, enforcing an
// inter-packet gap and lane readiness.
// Optional feature macro: DSI_SCHED_STARVE_GUARD_EN (command starvation guard).
module dsi_packet_scheduler
    import dsi_pkg::*;
#(
    parameter int GAP_CYCLES   = 16,  // 1..255
    parameter int STARVE_LIMIT = 4    // 0..255, guard build only
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    dsi_packet_scheduler_if.slave bus
);

    sched_state_t state_r;
    sched_state_t state_n;

    logic [7:0]            gap_cnt_r;
    logic [DSI_WORD_W-1:0] data_r;
    logic [4:0]            strb_r;
    logic                  last_r;
    logic                  grant_cmd_r;
    logic                  lp_r;
    logic                  held_r;       // output register holds a popped, unstarted word
    logic                  underflow_r;
    logic                  busy_r;

    logic [7:0]            starve_cnt_s;
    logic                  sel_cmd_s;
    logic                  sel_any_s;

    logic                  grant_s;
    logic                  pop_s;
    logic                  rqst_s;
    logic                  underflow_s;
    logic                  finish_s;

    logic                  src_valid_s;
    logic                  src_last_s;
    logic [DSI_WORD_W-1:0] src_data_s;
    logic [DSI_STRB_W-1:0] src_strb_s;

    dsi_sched_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .vid_valid  (bus.vid_valid),
        .cmd_valid  (bus.cmd_valid),
        .starve_cnt (starve_cnt_s),
        .sel_cmd    (sel_cmd_s),
        .sel_any    (sel_any_s)
    );

`ifdef DSI_SCHED_STARVE_GUARD_EN
    logic [7:0] starve_cnt_r;
    assign starve_cnt_s = starve_cnt_r;

    // Count video grants that bypass a waiting command; a command grant clears it.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 8'd0;
        end else if (grant_s) begin
            if (sel_cmd_s) begin
                starve_cnt_r <= 8'd0;
            end else if (bus.cmd_valid && (starve_cnt_r < 8'(STARVE_LIMIT))) begin
                starve_cnt_r <= starve_cnt_r + 8'd1;
            end
        end
    end
`else
    assign starve_cnt_s = 8'd0;
`endif

    // Route the granted source's word onto a common set of signals.
    always_comb begin
        if (grant_cmd_r) begin
            src_valid_s = bus.cmd_valid;
            src_last_s  = bus.cmd_last;
            src_data_s  = bus.cmd_data;
            src_strb_s  = bus.cmd_strb;
        end else begin
            src_valid_s = bus.vid_valid;
            src_last_s  = bus.vid_last;
            src_data_s  = bus.vid_data;
            src_strb_s  = bus.vid_strb;
        end
    end

    // Next-state and per-cycle control strobes of the scheduler FSM.
    always_comb begin
        state_n     = state_r;
        grant_s     = 1'b0;
        pop_s       = 1'b0;
        rqst_s      = 1'b0;
        underflow_s = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((gap_cnt_r == 8'd0) && bus.lines_ready) begin
                    if (held_r) begin
                        // Word from an aborted grant is still in the output register.
                        state_n = ST_START;
                    end else if (sel_any_s) begin
                        grant_s = 1'b1;
                        state_n = ST_LOAD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                pop_s = 1'b1;
                if (bus.lines_ready) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (bus.lines_ready) begin
                    rqst_s  = 1'b1;
                    state_n = ST_STREAM;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (bus.tx_data_rqst) begin
                    if (last_r) begin
                        finish_s = 1'b1;
                        state_n  = ST_GAP;
                    end else if (src_valid_s) begin
                        pop_s = 1'b1;
                    end else begin
                        underflow_s = 1'b1;
                        finish_s    = 1'b1;
                        state_n     = ST_GAP;
                    end
                end else begin
                    state_n = ST_STREAM;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r <= 8'd1) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Latch the grant decision and the packet mode at grant time.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            grant_cmd_r <= 1'b0;
            lp_r        <= DSI_MODE_HS;
        end else if (grant_s) begin
            grant_cmd_r <= sel_cmd_s;
            lp_r        <= sel_cmd_s ? bus.cmd_lp : DSI_MODE_HS;
        end
    end

    // Output word register: loaded on each pop, patched on underflow.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            strb_r <= 5'h00;
            last_r <= 1'b0;
        end else if (pop_s) begin
            data_r <= src_data_s;
            strb_r <= {lp_r, word_strb(src_last_s, src_strb_s)};
            last_r <= src_last_s;
        end else if (underflow_s) begin
            strb_r[3:0] <= 4'h0;
            last_r      <= 1'b1;
        end
    end

    // Remember a first word that was popped but whose start was aborted.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            held_r <= 1'b0;
        end else if (pop_s && (state_r == ST_LOAD)) begin
            held_r <= 1'b1;
        end else if (rqst_s) begin
            held_r <= 1'b0;
        end
    end

    // Inter-packet gap counter: loaded at packet end, counts down in GAP.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_r <= 8'd0;
        end else if (finish_s) begin
            gap_cnt_r <= 8'(GAP_CYCLES);
        end else if ((state_r == ST_GAP) && (gap_cnt_r != 8'd0)) begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
        end
    end

    // Sticky underflow flag and registered busy indication.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            underflow_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (underflow_s) begin
                underflow_r <= 1'b1;
            end
            busy_r <= (state_n != ST_IDLE);
        end
    end

    assign bus.vid_ready     = pop_s & ~grant_cmd_r;
    assign bus.cmd_ready     = pop_s &  grant_cmd_r;
    assign bus.tx_write_rqst = rqst_s;
    assign bus.tx_write_data = data_r;
    assign bus.tx_write_strb = strb_r;
    assign bus.tx_last_word  = last_r;
    assign bus.busy          = busy_r;
    assign bus.grant_cmd     = grant_cmd_r;
    assign bus.underflow_err = underflow_r;

endmodule

// File: tb/tb_dsi_packet_scheduler.sv
// Directed self-checking bench for dsi_packet_scheduler.
// The bench plays both packet sources and the lanes controller.
module tb_dsi_packet_scheduler;
    import dsi_pkg::*;

    localparam int GAP        = 16;
    localparam int DRQ_PERIOD = 4;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    dsi_packet_scheduler_if bus ();

    dsi_packet_scheduler #(
        .GAP_CYCLES   (GAP),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic        last;
        logic [3:0]  strb;
        logic [31:0] data;
    } src_word_t;

    typedef struct packed {
        logic        last;
        logic [4:0]  strb;
        logic [31:0] data;
    } out_word_t;

    src_word_t vid_q[$];
    src_word_t cmd_q[$];
    out_word_t got_q[$];
    logic      rq_grants[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rq_cnt = 0;
    int last_rq_cyc = 0;
    int last_drq_cyc = 0;
    int vid_pops = 0;
    int cmd_pops = 0;
    int drq_timer = 0;
    bit stream_on = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_srcs();
        if (vid_q.size() > 0) begin
            bus.vid_valid = 1'b1;
            bus.vid_last  = vid_q[0].last;
            bus.vid_strb  = vid_q[0].strb;
            bus.vid_data  = vid_q[0].data;
        end else begin
            bus.vid_valid = 1'b0;
            bus.vid_last  = 1'b0;
            bus.vid_strb  = 4'h0;
            bus.vid_data  = 32'h0;
        end
        if (cmd_q.size() > 0) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_last  = cmd_q[0].last;
            bus.cmd_strb  = cmd_q[0].strb;
            bus.cmd_data  = cmd_q[0].data;
        end else begin
            bus.cmd_valid = 1'b0;
            bus.cmd_last  = 1'b0;
            bus.cmd_strb  = 4'h0;
            bus.cmd_data  = 32'h0;
        end
    endtask

    // One clock per iteration: observe at negedge, update stimulus after posedge.
    task automatic run(input int n);
        logic vpop;
        logic cpop;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            cyc++;
            if (bus.tx_write_rqst) begin
                rq_cnt++;
                last_rq_cyc = cyc;
                rq_grants.push_back(bus.grant_cmd);
                stream_on = 1'b1;
                drq_timer = 0;
            end
            if (bus.tx_data_rqst) begin
                got_q.push_back({bus.tx_last_word, bus.tx_write_strb, bus.tx_write_data});
                last_drq_cyc = cyc;
                if (bus.tx_last_word) begin
                    stream_on = 1'b0;
                end
            end
            vpop = bus.vid_ready;
            cpop = bus.cmd_ready;
            @(posedge clk_sys);
            #1;
            if (vpop) begin
                vid_pops++;
                if (vid_q.size() > 0) void'(vid_q.pop_front());
            end
            if (cpop) begin
                cmd_pops++;
                if (cmd_q.size() > 0) void'(cmd_q.pop_front());
            end
            drive_srcs();
            if (stream_on) begin
                drq_timer++;
                if (drq_timer == DRQ_PERIOD) begin
                    bus.tx_data_rqst = 1'b1;
                    drq_timer = 0;
                end else begin
                    bus.tx_data_rqst = 1'b0;
                end
            end else begin
                bus.tx_data_rqst = 1'b0;
            end
        end
    endtask

    task automatic wait_rq(input int target, input int limit, input string tag);
        int n = 0;
        while ((rq_cnt < target) && (n < limit)) begin
            run(1);
            n++;
        end
        check_val(tag, 64'(rq_cnt >= target), 64'd1);
    endtask

    task automatic wait_got(input int target, input int limit, input string tag);
        int n = 0;
        while ((got_q.size() < target) && (n < limit)) begin
            run(1);
            n++;
        end
        check_val(tag, 64'(got_q.size() >= target), 64'd1);
    endtask

    initial begin
        int v;
        int base;
        int pops_base;
        int l_drq;

        bus.lines_ready  = 1'b1;
        bus.cmd_lp       = 1'b0;
        bus.tx_data_rqst = 1'b0;
        drive_srcs();

        // Reset state
        #12;
        check_val("rst_data", 64'(bus.tx_write_data), 64'h0);
        check_val("rst_strb", 64'(bus.tx_write_strb), 64'h0);
        check_val("rst_last", 64'(bus.tx_last_word), 64'h0);
        check_val("rst_rqst", 64'(bus.tx_write_rqst), 64'h0);
        check_val("rst_busy", 64'(bus.busy), 64'h0);
        check_val("rst_grant", 64'(bus.grant_cmd), 64'h0);
        check_val("rst_uflow", 64'(bus.underflow_err), 64'h0);
        check_val("rst_ready", 64'({bus.vid_ready, bus.cmd_ready}), 64'h0);
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        run(2);

        // Video only, 3 words
        got_q.delete();
        vid_q.push_back({1'b0, 4'h5, 32'hA000_0001});
        vid_q.push_back({1'b0, 4'h5, 32'hA000_0002});
        vid_q.push_back({1'b1, 4'h3, 32'hA000_0003});
        drive_srcs();
        v = cyc + 1;
        base = rq_cnt;
        wait_rq(base + 1, 10, "t1_rq_timeout");
        check_val("t1_rq_latency", 64'(last_rq_cyc - v), 64'd2);
        check_val("t1_grant", 64'(rq_grants[base]), 64'd0);
        wait_got(3, 40, "t1_words_timeout");
        check_val("t1_w0", 64'(got_q[0]), 64'({1'b0, 5'h0F, 32'hA000_0001}));
        check_val("t1_w1", 64'(got_q[1]), 64'({1'b0, 5'h0F, 32'hA000_0002}));
        check_val("t1_w2", 64'(got_q[2]), 64'({1'b1, 5'h03, 32'hA000_0003}));
        run(GAP + 4);

        // Both sources pending: video first, command GAP+3 after last video word
        got_q.delete();
        bus.cmd_lp = 1'b0;
        vid_q.push_back({1'b0, 4'hF, 32'hB000_0001});
        vid_q.push_back({1'b1, 4'h1, 32'hB000_0002});
        cmd_q.push_back({1'b1, 4'h6, 32'hC000_0001});
        drive_srcs();
        base = rq_cnt;
        wait_rq(base + 1, 10, "t2_rq1_timeout");
        check_val("t2_first_grant", 64'(rq_grants[base]), 64'd0);
        wait_got(2, 40, "t2_vid_timeout");
        l_drq = last_drq_cyc;
        wait_rq(base + 2, 40, "t2_rq2_timeout");
        check_val("t2_gap_spacing", 64'(last_rq_cyc - l_drq), 64'(GAP + 3));
        check_val("t2_second_grant", 64'(rq_grants[base + 1]), 64'd1);
        wait_got(3, 20, "t2_cmd_timeout");
        check_val("t2_cmd_word", 64'(got_q[2]), 64'({1'b1, 5'h06, 32'hC000_0001}));
        run(GAP + 4);

        // Continuous video with a pending LP command
        got_q.delete();
        bus.cmd_lp = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            vid_q.push_back({1'b1, 4'h7, 32'hD000_0000 + 32'(k)});
        end
        cmd_q.push_back({1'b1, 4'hC, 32'hCC00_0001});
        drive_srcs();
        base = rq_cnt;
        wait_got(6, 300, "t3_timeout");
`ifdef DSI_SCHED_STARVE_GUARD_EN
        check_val("t3_grant4", 64'(rq_grants[base + 3]), 64'd0);
        check_val("t3_grant5", 64'(rq_grants[base + 4]), 64'd1);
        check_val("t3_grant6", 64'(rq_grants[base + 5]), 64'd0);
        check_val("t3_word5", 64'(got_q[4]), 64'({1'b1, 5'h1C, 32'hCC00_0001}));
`else
        check_val("t3_grant4", 64'(rq_grants[base + 3]), 64'd0);
        check_val("t3_grant5", 64'(rq_grants[base + 4]), 64'd0);
        check_val("t3_grant6", 64'(rq_grants[base + 5]), 64'd1);
        check_val("t3_word5", 64'(got_q[4]), 64'({1'b1, 5'h07, 32'hD000_0005}));
        check_val("t3_word6", 64'(got_q[5]), 64'({1'b1, 5'h1C, 32'hCC00_0001}));
`endif
        bus.cmd_lp = 1'b0;
        run(GAP + 4);

        // Underflow: source runs dry mid-packet
        got_q.delete();
        check_val("t4_uflow_before", 64'(bus.underflow_err), 64'd0);
        vid_q.push_back({1'b0, 4'h9, 32'hE000_0001});
        drive_srcs();
        base = rq_cnt;
        wait_rq(base + 1, 10, "t4_rq_timeout");
        wait_got(1, 20, "t4_drq_timeout");
        stream_on = 1'b0;
        check_val("t4_uflow_set", 64'(bus.underflow_err), 64'd1);
        check_val("t4_forced_last", 64'(bus.tx_last_word), 64'd1);
        check_val("t4_forced_strb", 64'(bus.tx_write_strb), 64'h00);
        check_val("t4_held_data", 64'(bus.tx_write_data), 64'hE000_0001);
        check_val("t4_busy_gap", 64'(bus.busy), 64'd1);
        run(GAP + 4);
        check_val("t4_uflow_sticky", 64'(bus.underflow_err), 64'd1);
        check_val("t4_idle", 64'(bus.busy), 64'd0);

        // Lanes drop during LOAD: abort, then resend without a second pop
        got_q.delete();
        vid_q.push_back({1'b0, 4'h0, 32'hF000_0001});
        vid_q.push_back({1'b0, 4'h0, 32'hF000_0002});
        vid_q.push_back({1'b1, 4'hE, 32'hF000_0003});
        drive_srcs();
        base = rq_cnt;
        pops_base = vid_pops;
        run(1);
        bus.lines_ready = 1'b0;
        run(4);
        check_val("t5_no_rqst", 64'(rq_cnt - base), 64'd0);
        check_val("t5_one_pop", 64'(vid_pops - pops_base), 64'd1);
        check_val("t5_aborted_idle", 64'(bus.busy), 64'd0);
        bus.lines_ready = 1'b1;
        wait_got(3, 40, "t5_words_timeout");
        check_val("t5_rq_count", 64'(rq_cnt - base), 64'd1);
        check_val("t5_total_pops", 64'(vid_pops - pops_base), 64'd3);
        check_val("t5_w0", 64'(got_q[0]), 64'({1'b0, 5'h0F, 32'hF000_0001}));
        check_val("t5_w2", 64'(got_q[2]), 64'({1'b1, 5'h0E, 32'hF000_0003}));
        run(GAP + 4);

        // Asynchronous reset mid-stream
        got_q.delete();
        vid_q.push_back({1'b0, 4'h0, 32'h1234_0001});
        vid_q.push_back({1'b0, 4'h0, 32'h1234_0002});
        vid_q.push_back({1'b1, 4'hF, 32'h1234_0003});
        drive_srcs();
        base = rq_cnt;
        wait_rq(base + 1, 10, "t6_rq_timeout");
        wait_got(1, 20, "t6_drq_timeout");
        run(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_data0", 64'(bus.tx_write_data), 64'h0);
        check_val("t6_strb0", 64'(bus.tx_write_strb), 64'h0);
        check_val("t6_last0", 64'(bus.tx_last_word), 64'h0);
        check_val("t6_busy0", 64'(bus.busy), 64'h0);
        check_val("t6_uflow0", 64'(bus.underflow_err), 64'h0);
        check_val("t6_ready0", 64'({bus.vid_ready, bus.cmd_ready, bus.tx_write_rqst}), 64'h0);
        vid_q.delete();
        stream_on = 1'b0;
        bus.tx_data_rqst = 1'b0;
        drive_srcs();
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        base = rq_cnt;
        run(3);
        check_val("t6_idle_after", 64'(bus.busy), 64'd0);
        check_val("t6_no_rqst", 64'(rq_cnt - base), 64'd0);
        vid_q.push_back({1'b1, 4'h1, 32'h5555_0001});
        drive_srcs();
        v = cyc + 1;
        wait_rq(base + 1, 10, "t6_post_rq_timeout");
        check_val("t6_post_latency", 64'(last_rq_cyc - v), 64'd2);
        run(GAP + 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dsi_packet_scheduler.md
# dsi_packet_scheduler

Arbitrates two packet sources, the video stream engine and the host command queue, onto the single word interface of `dsi_lanes_controller`. It grants whole packets only, never preempting one mid-stream. It inserts a programmable inter-packet gap and gates traffic on lane readiness. It sits between the packet builders and the lanes controller in the `clk_sys` domain.

## Interface
**Parameters**
- `GAP_CYCLES`, default 16: minimum idle `clk_sys` cycles between the last word of one packet and the next grant; valid range 1..255.
- `STARVE_LIMIT`, default 4: consecutive video grants allowed while a command is pending. Used only with `DSI_SCHED_STARVE_GUARD_EN`.

**Ports**
- `clk_sys` in 1: the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `lines_ready` in 1: from the lanes controller; grants are issued only while this is 1.
- `vid_valid`, `vid_last` in 1 each: video source word valid and last-word flag.
- `vid_data` in 32: video source word.
- `vid_strb` in 4: byte strobes, meaningful on the last word only.
- `vid_ready` out 1: video source word accepted.
- `cmd_valid`, `cmd_last`, `cmd_data`, `cmd_strb`, `cmd_ready`: same meaning as the `vid_*` ports, for the command source.
- `cmd_lp` in 1: the command packet is sent in LP mode; sampled at grant.
- `tx_write_data` out 32: word to the lanes controller.
- `tx_write_strb` out 5: bits [3:0] are byte strobes; bit 4 is the mode (0 = HS, 1 = LP).
- `tx_write_rqst` out 1: one-cycle start pulse.
- `tx_last_word` out 1: the current `tx_write_data` is the final word.
- `tx_data_rqst` in 1: the lanes controller has consumed the current word.
- `busy` out 1: the scheduler is not in IDLE.
- `grant_cmd` out 1: the current or last grant went to the command source.
- `underflow_err` out 1: sticky; cleared only by reset.

## Operation
**States:** IDLE, LOAD, START, STREAM, GAP.

**IDLE**
- Leave IDLE only when the gap counter is 0, `lines_ready`=1, and at least one of `vid_valid`/`cmd_valid` is 1.
- Priority is video over command.
- With the starve guard: if `starve_cnt` equals `STARVE_LIMIT` and `cmd_valid`=1, command wins.
- Latch the selection into `grant_cmd` and go to LOAD.

**LOAD**
- Pulse the selected `*_ready` for 1 cycle.
- Register data, strobes and last into the output register.
- Output strobe handling: strobe = `*_strb` if last, else 4'hF.
- Mode bit: `cmd_lp` if a command is granted, 0 for video.
- Go to START.

**START**
- `tx_write_rqst`=1 for exactly 1 cycle, then go to STREAM.

**STREAM**, on `tx_data_rqst`:
- If the output register holds the last word: go to GAP and load the gap counter with `GAP_CYCLES`.
- Otherwise, if the source is valid: assert `*_ready` combinationally in the same cycle and load the next word into the output register.
- Otherwise (source not valid): set `underflow_err`, force `tx_last_word`=1 with strobe 4'h0 on the held word, and go to GAP.

**GAP**
- Decrement the gap counter to 0, then go to IDLE.

**Deassertion of `lines_ready`**
- In IDLE, LOAD or START: abort to IDLE without pulsing `tx_write_rqst`. A word already popped in LOAD is re-presented at the next grant; the output register is retained, so that grant skips LOAD.
- In STREAM: ignored.

**Starve counter**
- `starve_cnt`: increments on each video grant while `cmd_valid`=1.
- Clears on a command grant.
- Saturates at `STARVE_LIMIT`.

## Timing
- **Reset values:** all outputs 0, state IDLE, `starve_cnt` 0, gap counter 0.
- **Grant latency:** from a valid request in IDLE to `tx_write_rqst` is 2 cycles (LOAD, then START).
- **Word update:** `tx_write_data` changes on the clock edge after a `tx_data_rqst` cycle.
- **Last word:** `tx_last_word` is registered together with the data.
- **Packet-to-packet minimum:** last `tx_data_rqst` + `GAP_CYCLES` + 3 cycles to the next `tx_write_rqst`.
- **Simultaneous `vid_valid` and `cmd_valid`:** resolved purely by the priority rule; no round-robin.
- **`*_ready` rule:** never asserted for the source that is not granted.

## Configuration
- **`DSI_SCHED_STARVE_GUARD_EN` defined:** `starve_cnt` and the forced command grant are present.
- **Undefined:** strict video priority, no counter logic. `STARVE_LIMIT` is ignored.

## Structure
- **Package `dsi_pkg`:**
  - state enum `sched_state_t`;
  - `DSI_MODE_HS`=0, `DSI_MODE_LP`=1;
  - `DSI_WORD_W`=32.
- **Sub-module `dsi_sched_arbiter`:** combinational priority and starve logic.
  - Inputs: both valids, `starve_cnt`.
  - Outputs: `sel_cmd`, `sel_any`.
- The top level holds the FSM, the output register and the counters.

## Test plan
- **Video only:** 3-word video packet, `tx_data_rqst` every 4 cycles.
  - `tx_write_rqst` 2 cycles after `vid_valid`.
  - 3 data words delivered, `tx_last_word` on the 3rd, strb[4]=0.
- **Both sources pending:** both valid at once.
  - Video is granted first.
  - With `GAP_CYCLES`=16, the command starts exactly 19 cycles after the last video `tx_data_rqst`.
- **Starve guard:** `DSI_SCHED_STARVE_GUARD_EN`, `STARVE_LIMIT`=4, continuous video plus a pending command.
  - The 5th grant goes to command.
  - `grant_cmd`=1; with `cmd_lp`=1, strb[4]=1.
- **Underflow:** `vid_valid` dropped mid-packet while `tx_data_rqst` arrives.
  - `underflow_err` rises and stays set.
  - `tx_last_word`=1 with strb 4'h0, then GAP.
- **Lanes not ready:** `lines_ready` deasserted during LOAD.
  - No `tx_write_rqst`.
  - After re-assertion, the same first word is sent without a second `vid_ready` pulse.
- **Reset mid-STREAM:** async reset during a packet.
  - All outputs go to 0 immediately; state is IDLE after release.
